// File: rtl/mc_main_fsm.sv
// Main sequencing FSM for the multicycle ARM core: walks each instruction through
// fetch/decode/execute/writeback and drives datapath mux selects and write strobes.
module mc_main_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    typedef struct packed {
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       done;
    } moore_t;

    state_e state_q, state_d;
    moore_t mo_q;
    logic   rdy;
    logic   unused_funct;

    assign rdy          = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign unused_funct = ^Funct[4:1];

    function automatic moore_t moore_of(input state_e s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH, S_DECODE: begin
                m.alu_src_a  = 1'b1;
                m.alu_src_b  = 2'b10;
                m.result_src = 2'b10;
            end
            S_MEMADR: m.alu_src_b = 2'b01;
            S_MEMRD:  m.adr_src   = 1'b1;
            S_MEMWB: begin
                m.result_src = 2'b01;
                m.reg_w      = 1'b1;
                m.done       = 1'b1;
            end
            S_MEMWR: begin
                m.adr_src = 1'b1;
                m.mem_w   = 1'b1;
            end
            S_EXECR:  m.alu_op = 1'b1;
            S_EXECI: begin
                m.alu_src_b = 2'b01;
                m.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                m.reg_w = 1'b1;
                m.done  = 1'b1;
            end
            S_BRANCH: begin
                m.alu_src_b  = 2'b01;
                m.result_src = 2'b10;
                m.branch     = 1'b1;
                m.done       = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // NOTE: Moore outputs are registered by decoding the next state, so they
    // line up with state_q in the same cycle without a combinational decode path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            mo_q    <= moore_of(S_FETCH);
        end else begin
            state_q <= state_d;
            mo_q    <= moore_of(state_d);
        end
    end

    assign AdrSrc    = mo_q.adr_src;
    assign ALUSrcA   = mo_q.alu_src_a;
    assign ALUSrcB   = mo_q.alu_src_b;
    assign ResultSrc = mo_q.result_src;
    assign ALUOp     = mo_q.alu_op;
    assign RegW      = mo_q.reg_w;
    assign MemW      = mo_q.mem_w;
    assign Branch    = mo_q.branch;

    // Fetch strobes follow mem_ready in the same cycle; masked while reset is
    // held so a ready memory cannot advance the PC before the core runs.
    assign IRWrite    = reset & (state_q == S_FETCH) & rdy;
    assign NextPC     = IRWrite;
    assign illegal_op = (state_q == S_DECODE) & (Op == 2'b11);
    assign instr_done = mo_q.done | ((state_q == S_MEMWR) & rdy) | illegal_op;
    assign dbg_state  = STATE_W'(state_q);

endmodule
